// File: rtl/pong_frame_renderer.sv
// pong_frame_renderer: snapshots arena/ball/paddle state per frame and streams raster pixels over valid/ready.
// Define PONG_RENDER_BORDER_EN to also paint the arena edge in FG_COLOR.
module pong_frame_renderer #(
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W = 4,
  parameter int PADDLE_H = 32,
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dimensions,
  input  logic [31:0] ballPosition,
  input  logic [31:0] leftPaddlePosition,
  input  logic [31:0] rightPaddlePosition,
  input  logic        frameStart,
  input  logic        pixelReady,
  output logic        pixelValid,
  output logic [7:0]  pixelData,
  output logic        pixelFirst,
  output logic        pixelLast,
  output logic        frameBusy,
  output logic        frameDone
);
  typedef enum logic [1:0] {IDLE, LATCH, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] dim_q, dim_d, ball_q, ball_d, lpad_q, lpad_d, rpad_q, rpad_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic [7:0] data_q, data_d;
  logic row_end, hit, border;

  // 17-bit compares so objects placed near 16'hFFFF cannot wrap onto the screen
  function automatic logic covers(input logic [31:0] pos, input logic [15:0] cx, input logic [15:0] cy,
                                  input logic [16:0] sw, input logic [16:0] sh);
    return ({1'b0, cx} >= {1'b0, pos[31:16]}) && ({1'b0, cx} < {1'b0, pos[31:16]} + sw) &&
           ({1'b0, cy} >= {1'b0, pos[15:0]}) && ({1'b0, cy} < {1'b0, pos[15:0]} + sh);
  endfunction

  always_comb begin
    state_d = state_q;
    dim_d = dim_q;
    ball_d = ball_q;
    lpad_d = lpad_q;
    rpad_d = rpad_q;
    x_d = x_q;
    y_d = y_q;
    row_end = x_q == dim_q[31:16] - 16'd1;
    case (state_q)
      IDLE: state_d = frameStart ? LATCH : IDLE;
      LATCH: begin
        dim_d = dimensions;
        ball_d = ballPosition;
        lpad_d = leftPaddlePosition;
        rpad_d = rightPaddlePosition;
        x_d = '0;
        y_d = '0;
        state_d = (dimensions[31:16] == '0 || dimensions[15:0] == '0) ? DONE : STREAM;
      end
      STREAM: if (valid_q && pixelReady) begin
        x_d = row_end ? '0 : x_q + 16'd1;
        y_d = row_end ? y_q + 16'd1 : y_q;
        state_d = (row_end && y_q == dim_q[15:0] - 16'd1) ? DONE : STREAM;
      end
      default: state_d = IDLE;
    endcase
    // the output register always holds the pixel at (x_d, y_d), so it is stable during stalls
    valid_d = state_d == STREAM;
    hit = covers(ball_d, x_d, y_d, 17'(BALL_SIZE), 17'(BALL_SIZE)) ||
          covers(lpad_d, x_d, y_d, 17'(PADDLE_W), 17'(PADDLE_H)) ||
          covers(rpad_d, x_d, y_d, 17'(PADDLE_W), 17'(PADDLE_H));
`ifdef PONG_RENDER_BORDER_EN
    border = x_d == '0 || x_d == dim_d[31:16] - 16'd1 || y_d == '0 || y_d == dim_d[15:0] - 16'd1;
`else
    border = 1'b0;
`endif
    data_d = valid_d ? ((hit || border) ? FG_COLOR : BG_COLOR) : 8'h00;
    first_d = valid_d && x_d == '0 && y_d == '0;
    last_d = valid_d && x_d == dim_d[31:16] - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dim_q <= '0;
      ball_q <= '0;
      lpad_q <= '0;
      rpad_q <= '0;
      x_q <= '0;
      y_q <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      dim_q <= dim_d;
      ball_q <= ball_d;
      lpad_q <= lpad_d;
      rpad_q <= rpad_d;
      x_q <= x_d;
      y_q <= y_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

  assign pixelValid = valid_q;
  assign pixelData = data_q;
  assign pixelFirst = first_q;
  assign pixelLast = last_q;
  assign frameBusy = state_q == LATCH || state_q == STREAM;
  assign frameDone = state_q == DONE;
endmodule

// File: tb/tb_pong_frame_renderer.sv
// tb_pong_frame_renderer: table of frames with hand-computed foreground masks, plus mid-frame restart/reset sequence.
module tb_pong_frame_renderer;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] dimensions = '0, ballPosition = '0, leftPaddlePosition = '0, rightPaddlePosition = '0;
  logic frameStart = 1'b0, pixelReady = 1'b0;
  logic pixelValid, pixelFirst, pixelLast, frameBusy, frameDone;
  logic [7:0] pixelData;
  int checks = 0, errors = 0;

  pong_frame_renderer dut (
    .clk(clk), .rst(rst), .dimensions(dimensions), .ballPosition(ballPosition),
    .leftPaddlePosition(leftPaddlePosition), .rightPaddlePosition(rightPaddlePosition),
    .frameStart(frameStart), .pixelReady(pixelReady), .pixelValid(pixelValid), .pixelData(pixelData),
    .pixelFirst(pixelFirst), .pixelLast(pixelLast), .frameBusy(frameBusy), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dims, ball, lp, rp;
    logic [127:0] mask;
    bit rnd;
  } vec_t;
  vec_t vecs[10];
  localparam logic [127:0] MASK_A = 128'hFFFF_FFFF_FFFF_FFFF_0FFF_0FFF_000F_000F;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] expect_pix(input logic [127:0] mask, input int n, input int w, input int h);
    bit fg;
    fg = mask[n[6:0]];
`ifdef PONG_RENDER_BORDER_EN
    fg = fg || (n % w == 0) || (n % w == w - 1) || (n / w == 0) || (n / w == h - 1);
`endif
    return fg ? 8'hFF : 8'h00;
  endfunction

  task automatic run_frame(input vec_t v);
    int w, h, wd, n, k;
    bit done, stalled;
    logic [7:0] sd;
    logic sf, sl;
    w = int'(v.dims[31:16]);
    h = int'(v.dims[15:0]);
    wd = (w == 0) ? 1 : w;
    n = 0;
    k = 2;
    done = 0;
    stalled = 0;
    @(negedge clk);
    dimensions = v.dims;
    ballPosition = v.ball;
    leftPaddlePosition = v.lp;
    rightPaddlePosition = v.rp;
    pixelReady = 1'b1;
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    check("latch_busy", frameBusy, 1);
    check("latch_valid", pixelValid, 0);
    while (!done && k < 1000) begin
      @(negedge clk);
      pixelReady = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check("stall_data", pixelData, sd);
        check("stall_flags", {pixelValid, pixelFirst, pixelLast}, {1'b1, sf, sl});
      end
      stalled = pixelValid && !pixelReady;
      sd = pixelData;
      sf = pixelFirst;
      sl = pixelLast;
      if (frameDone) begin
        done = 1;
        check("done_busy", frameBusy, 0);
        check("done_valid", pixelValid, 0);
        check("done_count", n, w * h);
        if (!v.rnd) check("done_cycle", k, 2 + w * h);
      end else begin
        check("busy", frameBusy, 1);
        if (pixelValid && pixelReady) begin
          check("pixel", pixelData, expect_pix(v.mask, n, wd, h));
          check("first", pixelFirst, n == 0);
          check("last", pixelLast, n % wd == wd - 1);
          n++;
        end
      end
      k++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_pulse", frameDone, 0);
  endtask

  initial begin
    vecs[0] = '{32'h0010_0008, 32'h0004_0002, 32'h0000_0000, 32'h000C_0004, MASK_A, 1'b0};
    vecs[1] = '{32'h0010_0008, 32'h0004_0002, 32'h0000_0000, 32'h000C_0004, MASK_A, 1'b1};
    vecs[2] = '{32'h0004_0004, 32'hFFFC_FFFC, 32'hFFF0_FFF0, 32'hFFF0_FFF0, 128'h0, 1'b0};
    vecs[3] = '{32'h0004_0004, 32'h0001_0001, 32'h0064_0064, 32'h0064_0064, 128'hEEE0, 1'b0};
    vecs[4] = '{32'h0005_0003, 32'h0032_0032, 32'h0003_0001, 32'h0200_0000, 128'h6300, 1'b0};
    vecs[5] = '{32'h0008_0002, 32'h0007_0001, 32'h0000_0002, 32'h0002_0000, 128'hBC3C, 1'b0};
    vecs[6] = '{32'h0010_0001, 32'h0003_0000, 32'h0000_0001, 32'h000E_FFE0, 128'h07F8, 1'b0};
    vecs[7] = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 128'h0, 1'b0};
    vecs[8] = '{32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 128'h0, 1'b0};
    vecs[9] = '{32'h0004_0004, 32'h0100_0100, 32'h0100_0100, 32'h0100_0100, 128'h0, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_valid", pixelValid, 0);
    check("rst_data", pixelData, 0);
    check("rst_flags", {pixelFirst, pixelLast, frameBusy, frameDone}, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run_frame(vecs[i]);
    // restart attempt and input changes mid-stream, then reset at pixel 20
    @(negedge clk);
    dimensions = vecs[0].dims;
    ballPosition = vecs[0].ball;
    leftPaddlePosition = vecs[0].lp;
    rightPaddlePosition = vecs[0].rp;
    pixelReady = 1'b1;
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("mid_valid", pixelValid, 1);
      check("mid_pixel", pixelData, expect_pix(MASK_A, k, 16, 8));
      check("mid_first", pixelFirst, k == 0);
      if (k == 5) begin
        frameStart = 1'b1;
        dimensions = 32'h0004_0004;
        ballPosition = 32'h0008_0000;
        rightPaddlePosition = 32'h0008_0000;
      end
      if (k == 6) frameStart = 1'b0;
    end
    @(negedge clk);
    check("mid_pixel20", pixelData, expect_pix(MASK_A, 20, 16, 8));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", pixelValid, 0);
    check("mrst_data", pixelData, 0);
    check("mrst_flags", {pixelFirst, pixelLast, frameBusy, frameDone}, 0);
    repeat (6) begin
      @(negedge clk);
      check("mrst_no_done", {frameDone, pixelValid, frameBusy}, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
